seg_scan_decoder: RTL and testbench

Recovers the displayed time from the multiplexed seven-segment drive (`com`/`seg`) produced by the nap machine display path and republishes it as six BCD digits. It is the decoding end of the digit-encode and scan chain. It sits beside the display driver on the same clock, as a self-check and readback monitor. It filters scan transitions, decodes each stable digit pattern back to BCD, assembles complete six-digit frames and flags bad patterns, out-of-range times and a stalled scan.

---
 rtl/seg_scan_decoder_if.sv | 22 ++
 rtl/seg_scan_decoder.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_decoder_if.sv
// Scan-side bus of seg_scan_decoder: multiplexed seven-segment drive in,
// recovered six-digit BCD time and status flags out.
interface seg_scan_decoder_if;
    logic [7:0]  com;
    logic [6:0]  seg;
    logic        clr_err;
    logic [23:0] time_out;
    logic [5:0]  blank_mask;
    logic        frame_valid;
    logic        pat_err;
    logic        range_err;
    logic        stale;

    modport master (
        output com, seg, clr_err,
        input  time_out, blank_mask, frame_valid, pat_err, range_err, stale
    );
    modport slave (
        input  com, seg, clr_err,
        output time_out, blank_mask, frame_valid, pat_err, range_err, stale
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Readback monitor: filters the com/seg scan, decodes digits back to BCD and publishes
// complete six-digit frames. Optional frame range check under SEG_RANGE_CHECK_EN.
module seg_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 2000000
) (
    input  logic              clock,
    input  logic              reset,
    seg_scan_decoder_if.slave bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;

    state_t          r_state, w_state_n;
    logic [CW-1:0]   r_cnt, w_cnt_n, w_inc;
    logic [5:0]      r_com_prev;
    logic [6:0]      r_seg_prev;
    logic [5:0][3:0] r_digit, r_time_out;
    logic [5:0]      r_seen, w_seen_n, r_blank, r_blank_mask;
    logic            r_frame_valid, r_pat_err;
    logic [TW-1:0]   r_to_cnt;
    logic            w_chg, w_sel_ok, w_sample, w_restart;
    logic [2:0]      w_pos;
    logic            w_legal, w_blank;
    logic [3:0]      w_bcd;
    logic            w_complete, w_range_ok, w_pub;
    logic            w_unused_com;

    // com[1:0] drive digits this monitor does not track
    assign w_unused_com = ^bus.com[1:0];

    assign w_chg      = (bus.com[7:2] != r_com_prev) || (bus.seg != r_seg_prev);
    assign w_sel_ok   = $onehot(~bus.com[7:2]);
    assign w_inc      = r_cnt + 1'b1;
    assign w_complete = &r_seen;
    assign w_pub      = w_complete & w_range_ok;

    always_comb begin
        w_pos = 3'd0;
        for (int i = 0; i < 6; i++)
            if (!bus.com[i+2]) w_pos = 3'(i);
    end

    always_comb begin
        w_legal = 1'b1;
        w_blank = 1'b0;
        w_bcd   = 4'd0;
        case (bus.seg)
            7'h7E: w_bcd = 4'd0;
            7'h30: w_bcd = 4'd1;
            7'h6D: w_bcd = 4'd2;
            7'h79: w_bcd = 4'd3;
            7'h33: w_bcd = 4'd4;
            7'h5B: w_bcd = 4'd5;
            7'h5F: w_bcd = 4'd6;
            7'h70: w_bcd = 4'd7;
            7'h7F: w_bcd = 4'd8;
            7'h7B: w_bcd = 4'd9;
            7'h00: begin w_legal = 1'b0; w_blank = 1'b1; end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // The cycle of a change counts as the first stable cycle of the new pair
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_sample  = 1'b0;
        w_restart = 1'b0;
        case (r_state)
            S_WAIT:   w_restart = 1'b1;
            S_SETTLE: begin
                if (w_chg) begin
                    w_restart = 1'b1;
                end else if (w_inc == CNT_LAST) begin
                    w_sample  = 1'b1;
                    w_state_n = S_HOLD;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = w_inc;
                end
            end
            S_HOLD:   if (w_chg) w_restart = 1'b1;
            default:  w_state_n = S_WAIT;
        endcase
        if (w_restart) begin
            w_cnt_n = '0;
            if (!w_sel_ok) begin
                w_state_n = S_WAIT;
            end else if (SETTLE == 1) begin
                w_sample  = 1'b1;
                w_state_n = S_HOLD;
            end else begin
                w_state_n = S_SETTLE;
            end
        end
    end

    always_comb begin
        w_seen_n = w_complete ? 6'd0 : r_seen;
        if (w_sample && (w_legal || w_blank)) w_seen_n[w_pos] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_com_prev    <= 6'h3F;
            r_seg_prev    <= 7'h00;
            r_digit       <= '0;
            r_seen        <= '0;
            r_blank       <= '0;
            r_time_out    <= '0;
            r_blank_mask  <= '0;
            r_frame_valid <= 1'b0;
            r_pat_err     <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_com_prev    <= bus.com[7:2];
            r_seg_prev    <= bus.seg;
            r_seen        <= w_seen_n;
            r_frame_valid <= w_pub;
            r_pat_err     <= (w_sample & ~w_legal & ~w_blank) | (r_pat_err & ~bus.clr_err);
            if (w_pub) begin
                r_time_out   <= r_digit;
                r_blank_mask <= r_blank;
            end
            if (w_pub)
                r_to_cnt <= '0;
            else if (r_to_cnt != TO_MAX)
                r_to_cnt <= r_to_cnt + 1'b1;
            // A blank digit inherits the value published as of this edge
            if (w_sample && w_legal) begin
                r_digit[w_pos] <= w_bcd;
                r_blank[w_pos] <= 1'b0;
            end else if (w_sample && w_blank) begin
                r_digit[w_pos] <= w_pub ? r_digit[w_pos] : r_time_out[w_pos];
                r_blank[w_pos] <= 1'b1;
            end
        end
    end

`ifdef SEG_RANGE_CHECK_EN
    logic r_range_err;

    assign w_range_ok = ((r_digit[5] < 4'd2) || (r_digit[5] == 4'd2 && r_digit[4] <= 4'd3)) &&
                        (r_digit[3] <= 4'd5) && (r_digit[1] <= 4'd5);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_range_err <= 1'b0;
        else       r_range_err <= w_complete & ~w_range_ok;
    end

    assign bus.range_err = r_range_err;
`else
    assign w_range_ok    = 1'b1;
    assign bus.range_err = 1'b0;
`endif

    assign bus.time_out    = r_time_out;
    assign bus.blank_mask  = r_blank_mask;
    assign bus.frame_valid = r_frame_valid;
    assign bus.pat_err     = r_pat_err;
    assign bus.stale       = (r_to_cnt == TO_MAX);
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: frame table, hand-written corner sequences and a random
// scan checked every cycle against a run-length behavioural model.
module tb_seg_scan_decoder;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;
`ifdef SEG_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_decoder_if bus();

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] LUT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    typedef struct {
        logic [23:0] digs;      // nibble F = blank
        logic [23:0] exp_time;
        logic [5:0]  exp_mask;
        int          exp_fv;
        int          exp_re;
    } vec_t;
    vec_t vecs [5];

    int n_chk = 0, n_err = 0, fv_cnt = 0, re_cnt = 0;

    // Behavioural model: a digit is taken when its com/seg pair has been seen for SETTLE
    // consecutive cycles with exactly one digit selected.
    logic [5:0] m_pcom;
    logic [6:0] m_pseg;
    int m_len, m_to;
    int m_dig [6], m_pub [6];
    bit m_blk [6], m_pblk [6], m_seen [6];
    bit m_fv, m_re, m_pe;

    function automatic int dec(logic [6:0] s);
        if (s == 7'h00) return 10;
        for (int i = 0; i < 10; i++) if (LUT[i] == s) return i;
        return -1;
    endfunction

    function automatic int pos_of(logic [5:0] c);
        int n = 0, p = -1;
        for (int i = 0; i < 6; i++) if (!c[i]) begin n++; p = i; end
        return (n == 1) ? p : -1;
    endfunction

    function automatic logic [6:0] pat(int d);
        return (d > 9) ? 7'h00 : LUT[d];
    endfunction

    function automatic logic [23:0] mtime();
        logic [23:0] t;
        for (int i = 0; i < 6; i++) t[i*4 +: 4] = 4'(m_pub[i]);
        return t;
    endfunction

    function automatic logic [5:0] mmask();
        logic [5:0] b;
        for (int i = 0; i < 6; i++) b[i] = m_pblk[i];
        return b;
    endfunction

    task automatic model_reset();
        m_pcom = 6'h3F; m_pseg = 7'h00; m_len = 0; m_to = 0;
        m_fv = 0; m_re = 0; m_pe = 0;
        for (int i = 0; i < 6; i++) begin
            m_dig[i] = 0; m_pub[i] = 0; m_blk[i] = 0; m_pblk[i] = 0; m_seen[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit complete, ok, pe_set;
        int p, d;
        complete = 1; ok = 1; pe_set = 0;
        for (int i = 0; i < 6; i++) if (!m_seen[i]) complete = 0;
        m_fv = 0; m_re = 0;
        if (complete) begin
            if (RC) ok = (m_dig[5]*10 + m_dig[4] <= 23) && (m_dig[3] <= 5) && (m_dig[1] <= 5);
            if (ok) begin m_pub = m_dig; m_pblk = m_blk; m_fv = 1; end
            else m_re = 1;
            for (int i = 0; i < 6; i++) m_seen[i] = 0;
        end
        if (complete && ok) m_to = 0;
        else if (m_to < TIMEOUT) m_to++;
        if (bus.com[7:2] == m_pcom && bus.seg == m_pseg) m_len++;
        else m_len = 1;
        m_pcom = bus.com[7:2]; m_pseg = bus.seg;
        p = pos_of(bus.com[7:2]);
        if (m_len == SETTLE && p >= 0) begin
            d = dec(bus.seg);
            if (d < 0) pe_set = 1;
            else if (d == 10) begin m_dig[p] = m_pub[p]; m_blk[p] = 1; m_seen[p] = 1; end
            else begin m_dig[p] = d; m_blk[p] = 0; m_seen[p] = 1; end
        end
        m_pe = pe_set || (m_pe && !bus.clr_err);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        @(negedge clk);
        if (bus.frame_valid) fv_cnt++;
        if (bus.range_err) re_cnt++;
        chk("time_out", bus.time_out, mtime());
        chk("blank_mask", bus.blank_mask, mmask());
        chk("frame_valid", bus.frame_valid, m_fv);
        chk("pat_err", bus.pat_err, m_pe);
        chk("range_err", bus.range_err, m_re);
        chk("stale", bus.stale, (m_to == TIMEOUT));
    endtask

    task automatic put(logic [7:0] c, logic [6:0] s, int n);
        bus.com = c; bus.seg = s;
        repeat (n) tick();
    endtask

    task automatic scan_dig(int p, logic [6:0] s, int n);
        logic [7:0] c;
        c = 8'h04 << p;
        put(~c, s, n);
    endtask

    task automatic scan_frame(logic [23:0] digs);
        for (int p = 5; p >= 0; p--) scan_dig(p, pat(int'(digs[p*4 +: 4])), 10);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_time"}, bus.time_out, 0);
        chk({tag, "_mask"}, bus.blank_mask, 0);
        chk({tag, "_fv"}, bus.frame_valid, 0);
        chk({tag, "_pe"}, bus.pat_err, 0);
        chk({tag, "_re"}, bus.range_err, 0);
        chk({tag, "_stale"}, bus.stale, 0);
    endtask

    initial begin
        vecs[0] = '{24'h123456, 24'h123456, 6'b000000, 1, 0};
        vecs[1] = '{24'h12FF56, 24'h123456, 6'b001100, 1, 0};
        vecs[2] = '{24'h250000, RC ? 24'h123456 : 24'h250000, 6'b000000, RC ? 0 : 1, RC ? 1 : 0};
        vecs[3] = '{24'h095959, 24'h095959, 6'b000000, 1, 0};
        vecs[4] = '{24'hF35958, 24'h035958, 6'b100000, 1, 0};

        bus.com = 8'hFF; bus.seg = 7'h00; bus.clr_err = 1'b0;
        model_reset();
        repeat (2) tick();
        check_zero("reset");
        rst = 1'b0;

        // idle scan: stale rises exactly TIMEOUT cycles after reset release
        repeat (TIMEOUT - 1) tick();
        chk("stale_early", bus.stale, 0);
        tick();
        chk("stale_at_timeout", bus.stale, 1);

        foreach (vecs[v]) begin
            fv_cnt = 0; re_cnt = 0;
            put(8'hFF, 7'h00, 2);
            scan_frame(vecs[v].digs);
            put(8'hFF, 7'h00, 3);
            chk($sformatf("vec%0d_fv_count", v), fv_cnt, vecs[v].exp_fv);
            chk($sformatf("vec%0d_re_count", v), re_cnt, vecs[v].exp_re);
            chk($sformatf("vec%0d_time", v), bus.time_out, vecs[v].exp_time);
            chk($sformatf("vec%0d_mask", v), bus.blank_mask, vecs[v].exp_mask);
            chk($sformatf("vec%0d_stale", v), bus.stale, 0);
        end

        // illegal sec1 pattern, clear, then rescan with a legal 5
        fv_cnt = 0;
        put(8'hFF, 7'h00, 2);
        for (int p = 5; p >= 1; p--) scan_dig(p, pat(6 - p), 10);
        scan_dig(0, 7'h01, 3);
        chk("pat_err_before_sample", bus.pat_err, 0);
        tick();
        chk("pat_err_after_sample", bus.pat_err, 1);
        repeat (6) tick();
        chk("pat_err_no_frame", fv_cnt, 0);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0; tick();
        chk("pat_err_cleared", bus.pat_err, 0);
        scan_dig(0, 7'h5B, 10);
        chk("rescan_fv_count", fv_cnt, 1);
        chk("rescan_time", bus.time_out, 24'h123455);

        // hour10 toggling every 2 cycles (one value illegal) must never be sampled
        fv_cnt = 0;
        put(8'hFF, 7'h00, 2);
        for (int i = 0; i < 6; i++) put(8'h7F, (i % 2) ? 7'h01 : LUT[8], 2);
        chk("toggle_no_capture", bus.pat_err, 0);
        put(8'h7F, LUT[1], 6);
        scan_dig(4, LUT[7], 10); scan_dig(3, LUT[5], 10); scan_dig(2, LUT[9], 10);
        scan_dig(1, LUT[5], 10); scan_dig(0, LUT[8], 10);
        chk("toggle_fv_count", fv_cnt, 1);
        chk("toggle_time", bus.time_out, 24'h175958);

        // reset after three captured digits discards the partial frame
        put(8'hFF, 7'h00, 2);
        scan_dig(5, LUT[2], 10); scan_dig(4, LUT[0], 10); scan_dig(3, LUT[1], 10);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("midreset");
        repeat (2) tick();
        rst = 1'b0;
        fv_cnt = 0;
        scan_dig(2, LUT[3], 10); scan_dig(1, LUT[4], 10); scan_dig(0, LUT[5], 10);
        chk("after_reset_partial", fv_cnt, 0);
        chk("after_reset_time", bus.time_out, 0);
        put(8'hFF, 7'h00, 2);
        scan_frame(24'h201345);
        chk("after_reset_full", fv_cnt, 1);
        chk("after_reset_full_time", bus.time_out, 24'h201345);

        // random scan: mostly legal digits, some blanks, illegal patterns, bad selects
        for (int it = 0; it < 600; it++) begin
            logic [7:0] c;
            logic [6:0] s;
            int r, hold;
            r = $urandom_range(0, 99);
            if (r < 8) c = 8'($urandom);
            else begin c = 8'h04 << $urandom_range(0, 5); c = ~c; end
            r = $urandom_range(0, 99);
            if (r < 70) s = LUT[$urandom_range(0, 9)];
            else if (r < 85) s = 7'h00;
            else s = 7'($urandom);
            hold = $urandom_range(1, 8);
            bus.com = c; bus.seg = s;
            if ($urandom_range(0, 199) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end
            for (int k = 0; k < hold; k++) begin
                bus.clr_err = ($urandom_range(0, 9) == 0);
                tick();
            end
            bus.clr_err = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
